data_bus_responder: RTL and testbench
=====================================

Name: data_bus_responder

Overview:
- Slave end of the core's data bus. Services the `bus_wren` (store) and `bus_rden` (load) strobes driven by the control unit.
- Contains a byte-addressable data RAM and a small MMIO region: an 8-bit GPIO output register and a 32-bit free-running timer with a compare interrupt.
- Reads are combinational, so a single-cycle core gets load data in the same cycle. All state changes occur at the rising edge of `clk`.

Parameters:
- DATA_BASE, 32'h1001_0000, byte base address of the data RAM.
- RAM_WORDS, 1024, RAM depth in 32-bit words; must be a power of 2.
- MMIO_BASE, 32'hFFFF_0000, byte base of the MMIO register block, 32 bytes decoded.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- bus_wren  in  1  store request this cycle
- bus_rden  in  1  load request this cycle
- bus_addr  in  32  byte address
- bus_funct3  in  3  instruction funct3; selects access size and sign
- bus_wdata  in  32  store data, LSB-aligned
- bus_rdata  out  32  load data, sign- or zero-extended
- bus_fault  out  1  access error this cycle
- gpio_out  out  8  GPIO output register
- timer_irq  out  1  timer interrupt request

Behaviour:
- One clock (`clk`); reset (`rst`) is synchronous and active-high.
- Reset values:
  - `gpio_out` = 0; TIMER_CTRL = 0; pending = 0; MTIME = 0; MTIMECMP = 32'hFFFF_FFFF.
  - `timer_irq` = 0; `bus_fault` and `bus_rdata` = 0 when idle.
  - RAM contents are not reset.
- Address decode:
  - RAM hit: DATA_BASE ≤ addr < DATA_BASE + 4·RAM_WORDS.
  - MMIO hit: MMIO_BASE ≤ addr < MMIO_BASE + 32.
  - Anything else is unmapped.
- Store sizes (funct3): 000 SB, 001 SH, 010 SW. Other funct3 values fault.
- Load sizes (funct3): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Other funct3 values fault.
- `bus_fault` is combinational, asserted while `rden` or `wren` is high and any of these holds:
  - unmapped address;
  - illegal funct3;
  - misalignment (halfword with `addr[0]`, word with `addr[1:0]` ≠ 0);
  - MMIO access that is not a word (funct3 ≠ 010);
  - `rden` and `wren` high together.
- On a fault: no state is written and `bus_rdata` = 0.
- RAM store: byte-lane write at the rising edge. SB writes lane `addr[1:0]`; SH writes lanes {`addr[1]`,0} and {`addr[1]`,1}; SW writes all four lanes. Unwritten lanes are preserved.
- RAM load: combinational read of word `addr[N+1:2]`. Select the byte or half by `addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Read-during-write to the same address returns the old data, but loads and stores are never simultaneous (that case is a fault).
- MMIO map (offset from MMIO_BASE):
  - 0x00 GPIO: rw, bits [7:0]; reads return zero-extended value.
  - 0x04 TIMER_CTRL: rw; bit0 = count enable, bit1 = irq enable.
  - 0x08 TIMER_STATUS: bit0 = pending, write-1-to-clear.
  - 0x0C MTIME: rw.
  - 0x10 MTIMECMP: rw.
  - 0x14–0x1C: read 0, writes ignored, no fault.
- MTIME: increments by 1 each cycle while `CTRL.bit0` = 1, wrapping 32'hFFFF_FFFF → 0. A bus write to MTIME loads `wdata` and suppresses that cycle's increment.
- Pending flag:
  - Set on the edge after a cycle in which MTIME == MTIMECMP and `CTRL.bit0` = 1.
  - Sticky until cleared through STATUS.
  - If set and clear occur in the same cycle, set wins.
- `timer_irq` = pending & `CTRL.bit1`, registered (one cycle after pending).
- Compare uses the current (pre-increment) MTIME value.

Decomposition:
- Shared package `be_pkg` holds:
  - funct3 load/store constants as an enum;
  - MMIO offset localparams;
  - TIMER_CTRL bit-index constants.
- One sub-module, `bus_timer`, holds MTIME, MTIMECMP, CTRL, pending and `timer_irq`, with register-write and read-mux ports.
- RAM byte-lane logic and decode stay in the top.

Test Plan:
- SW 32'hDEAD_BEEF to 0x1001_0000 → LW = 32'hDEAD_BEEF; LB at +0 = 32'hFFFF_FFEF; LBU at +3 = 32'h0000_00DE; LHU at +2 = 32'h0000_DEAD.
- SB 8'h12 to 0x1001_0001 over 32'hDEAD_BEEF → LW = 32'hDEAD_12EF; SH 16'h8000 to +2 then LH at +2 = 32'hFFFF_8000.
- LW at 0x1001_0002, SH at 0x1001_0001, LW at 0x2000_0000, rden & wren together → `bus_fault` = 1 each time, `bus_rdata` = 0, RAM unchanged on re-read.
- Write GPIO = 32'h1A5 → `gpio_out` = 8'hA5, readback 32'h0000_00A5; SB to GPIO → fault, `gpio_out` unchanged.
- MTIMECMP = 5, CTRL = 3, MTIME = 0 → pending sets at MTIME = 6, `timer_irq` = 1 one cycle later. W1C on STATUS clears it. MTIME write of 32'hFFFF_FFFF wraps to 0 on the next cycle.
- Assert `rst` mid-count with irq high → next edge: MTIME = 0, `timer_irq` = 0, `gpio_out` = 0, MTIMECMP = 32'hFFFF_FFFF; RAM data written before reset is still readable.

Source files
------------

// File: rtl/be_pkg.sv
// Shared constants for the data bus responder: funct3 access codes, MMIO
// register offsets and timer control bit positions.
package be_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  localparam logic [4:0] OFF_GPIO     = 5'h00;
  localparam logic [4:0] OFF_CTRL     = 5'h04;
  localparam logic [4:0] OFF_STATUS   = 5'h08;
  localparam logic [4:0] OFF_MTIME    = 5'h0C;
  localparam logic [4:0] OFF_MTIMECMP = 5'h10;

  localparam int MMIO_SPAN = 32;

  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/bus_timer.sv
// Free-running 32-bit timer with compare, sticky pending flag and a
// registered interrupt output; exposes a register write port and a read mux.
module bus_timer
  import be_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_off_i,
  input  logic [31:0] wr_data_i,
  input  logic [4:0]  rd_off_i,
  output logic [31:0] rd_data_o,
  output logic        timer_irq_o
);

  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;
  logic        cmp_hit, status_clr;

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    ctrl_d     = ctrl_q;

    // Compare sees the pre-increment count; a set in the same cycle as a clear wins.
    cmp_hit    = ctrl_q[CTRL_CNT_EN] && (mtime_q == mtimecmp_q);
    status_clr = wr_en_i && (wr_off_i == OFF_STATUS) && wr_data_i[0];
    pending_d  = cmp_hit | (pending_q & ~status_clr);
    irq_d      = pending_q & ctrl_q[CTRL_IRQ_EN];

    if (wr_en_i && (wr_off_i == OFF_MTIME)) begin
      mtime_d = wr_data_i;
    end else if (ctrl_q[CTRL_CNT_EN]) begin
      mtime_d = mtime_q + 32'd1;
    end
    if (wr_en_i && (wr_off_i == OFF_MTIMECMP)) mtimecmp_d = wr_data_i;
    if (wr_en_i && (wr_off_i == OFF_CTRL))     ctrl_d     = wr_data_i[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= 32'd0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      ctrl_q     <= 2'b00;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    case (rd_off_i)
      OFF_CTRL:     rd_data_o = {30'd0, ctrl_q};
      OFF_STATUS:   rd_data_o = {31'd0, pending_q};
      OFF_MTIME:    rd_data_o = mtime_q;
      OFF_MTIMECMP: rd_data_o = mtimecmp_q;
      default:      rd_data_o = 32'd0;
    endcase
  end

  assign timer_irq_o = irq_q;

endmodule

// File: rtl/data_bus_responder.sv
// Data bus slave: byte-addressable RAM plus a GPIO/timer MMIO block.
// Loads are combinational; stores and register updates take effect at the clock edge.
module data_bus_responder
  import be_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = 32'h1001_0000,
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_wren,
  input  logic        bus_rden,
  input  logic [31:0] bus_addr,
  input  logic [2:0]  bus_funct3,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_fault,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int         IDX_W    = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_END  = {1'b0, DATA_BASE} + 33'(4 * RAM_WORDS);
  localparam logic [32:0] MMIO_END = {1'b0, MMIO_BASE} + 33'(MMIO_SPAN);

  logic [31:0]      mem_q [RAM_WORDS];
  logic [32:0]      addr_ext;
  logic             ram_hit, mmio_hit, legal_f3, misalign, wr_ok, rd_ok;
  logic [IDX_W-1:0] idx;
  logic [4:0]       mmio_off;
  logic [3:0]       be;
  logic [31:0]      st_data, ram_word, ram_load, mmio_load, timer_rd;
  logic [7:0]       ld_byte, gpio_q, gpio_d;
  logic [15:0]      ld_half;

  assign addr_ext = {1'b0, bus_addr};
  assign ram_hit  = (addr_ext >= {1'b0, DATA_BASE}) && (addr_ext < RAM_END);
  assign mmio_hit = (addr_ext >= {1'b0, MMIO_BASE}) && (addr_ext < MMIO_END);
  assign idx      = bus_addr[IDX_W+1:2];
  // MMIO_BASE is 32-byte aligned, so the low address bits are the register offset.
  assign mmio_off = bus_addr[4:0];

  always_comb begin
    case (bus_funct3)
      F3_B, F3_H, F3_W: legal_f3 = 1'b1;
      F3_BU, F3_HU:     legal_f3 = !bus_wren;
      default:          legal_f3 = 1'b0;
    endcase
  end

  assign misalign = ((bus_funct3[1:0] == 2'b01) && bus_addr[0]) ||
                    ((bus_funct3[1:0] == 2'b10) && (bus_addr[1:0] != 2'b00));

  assign bus_fault = (bus_wren | bus_rden) &
                     ((bus_wren & bus_rden) | ~(ram_hit | mmio_hit) | ~legal_f3 |
                      misalign | (mmio_hit & (bus_funct3 != F3_W)));

  assign wr_ok = bus_wren & ~bus_fault;
  assign rd_ok = bus_rden & ~bus_fault;

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (bus_funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << bus_addr[1:0];
        st_data = {4{bus_wdata[7:0]}};
      end
      2'b01: begin
        be      = bus_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = bus_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign ram_word = mem_q[idx];
  assign ld_half  = bus_addr[1] ? ram_word[31:16] : ram_word[15:0];

  always_comb begin
    case (bus_addr[1:0])
      2'b00:   ld_byte = ram_word[7:0];
      2'b01:   ld_byte = ram_word[15:8];
      2'b10:   ld_byte = ram_word[23:16];
      default: ld_byte = ram_word[31:24];
    endcase
    case (bus_funct3)
      F3_B:    ram_load = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ram_load = {{16{ld_half[15]}}, ld_half};
      F3_W:    ram_load = ram_word;
      F3_BU:   ram_load = {24'd0, ld_byte};
      F3_HU:   ram_load = {16'd0, ld_half};
      default: ram_load = 32'd0;
    endcase
  end

  always_comb begin
    gpio_d = gpio_q;
    if (wr_ok && mmio_hit && (mmio_off == OFF_GPIO)) gpio_d = bus_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) gpio_q <= 8'd0;
    else     gpio_q <= gpio_d;
  end

  bus_timer u_timer (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_ok & mmio_hit),
    .wr_off_i    (mmio_off),
    .wr_data_i   (bus_wdata),
    .rd_off_i    (mmio_off),
    .rd_data_o   (timer_rd),
    .timer_irq_o (timer_irq)
  );

  assign mmio_load = (mmio_off == OFF_GPIO) ? {24'd0, gpio_q} : timer_rd;
  assign bus_rdata = rd_ok ? (ram_hit ? ram_load : mmio_load) : 32'd0;
  assign gpio_out  = gpio_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Self-checking bench for data_bus_responder: directed RAM/MMIO/timer steps
// plus randomized RAM traffic checked against a byte-array reference model.
module tb_data_bus_responder;

  localparam logic [31:0] DB = 32'h1001_0000;
  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam logic [31:0] WB = DB + 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_wren, bus_rden;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [2:0]  bus_funct3;
  logic        bus_fault, timer_irq;
  logic [7:0]  gpio_out;

  int total = 0;
  int bad   = 0;
  logic [7:0] mb [64];

  always #5 clk = ~clk;

  data_bus_responder dut (
    .clk        (clk),
    .rst        (rst),
    .bus_wren   (bus_wren),
    .bus_rden   (bus_rden),
    .bus_addr   (bus_addr),
    .bus_funct3 (bus_funct3),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_fault  (bus_fault),
    .gpio_out   (gpio_out),
    .timer_irq  (timer_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a rising edge; outputs are checked at the falling edge.
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [2:0] f, input logic [31:0] d);
    bus_wren = w; bus_rden = r; bus_addr = a; bus_funct3 = f; bus_wdata = d;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus_wren = 1'b0; bus_rden = 1'b0; bus_addr = 32'd0; bus_funct3 = 3'd0; bus_wdata = 32'd0;
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    access(1'b1, 1'b0, a, f, d);
    chk({tag, "_flt"}, bus_fault, 1'b0);
    tick();
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f, input logic [31:0] exp);
    access(1'b0, 1'b1, a, f, 32'd0);
    chk({tag, "_flt"}, bus_fault, 1'b0);
    chk(tag, bus_rdata, exp);
    tick();
  endtask

  task automatic flt(input string tag, input logic w, input logic r, input logic [31:0] a,
                     input logic [2:0] f, input logic [31:0] d);
    access(w, r, a, f, d);
    chk({tag, "_flt"}, bus_fault, 1'b1);
    chk({tag, "_rd0"}, bus_rdata, 32'd0);
    tick();
  endtask

  // Reference: little-endian byte memory, size from funct3, extension by funct3[2].
  function automatic logic [31:0] mload(input int off, input logic [2:0] f);
    int n = 1 << f[1:0];
    logic [31:0] v = 32'd0;
    logic [31:0] mask;
    for (int i = 0; i < n; i++) v = v | (32'(mb[off+i]) << (8 * i));
    if (n < 4 && !f[2]) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      if (v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic bit mfault(input bit w, input bit r, input logic [31:0] a, input logic [2:0] f);
    bit is_ram  = (a >= DB) && (a < DB + 32'd4096);
    bit is_mmio = (a >= MB) && ((a - MB) < 32'd32);
    bit legal   = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
    int n       = 1 << f[1:0];
    if (!(w || r)) return 1'b0;
    return (w && r) || !(is_ram || is_mmio) || !legal || ((a % n) != 0) || (is_mmio && f != 3'd2);
  endfunction

  initial begin
    logic [31:0] a, d, v, exp_rd;
    logic [2:0]  f;
    bit          w, r, ef, seen;
    int          off, kind, nb, hit_at;

    rst = 1'b1;
    bus_wren = 1'b0; bus_rden = 1'b0; bus_addr = 32'd0; bus_funct3 = 3'd0; bus_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_gpio", gpio_out, 8'h00);
    chk("rst_irq", timer_irq, 1'b0);
    chk("idle_fault", bus_fault, 1'b0);
    chk("idle_rdata", bus_rdata, 32'd0);
    ld("rst_mtime", MB + 32'h0C, 3'd2, 32'd0);
    ld("rst_cmp", MB + 32'h10, 3'd2, 32'hFFFF_FFFF);
    ld("rst_ctrl", MB + 32'h04, 3'd2, 32'd0);
    ld("rst_status", MB + 32'h08, 3'd2, 32'd0);

    st("sw_base", DB, 3'd2, 32'hDEAD_BEEF);
    ld("lw_base", DB, 3'd2, 32'hDEAD_BEEF);
    ld("lb_0", DB, 3'd0, 32'hFFFF_FFEF);
    ld("lbu_3", DB + 3, 3'd4, 32'h0000_00DE);
    ld("lhu_2", DB + 2, 3'd5, 32'h0000_DEAD);
    st("sb_1", DB + 1, 3'd0, 32'hFFFF_FF12);
    ld("lw_after_sb", DB, 3'd2, 32'hDEAD_12EF);
    st("sh_2", DB + 2, 3'd1, 32'h1234_8000);
    ld("lh_2", DB + 2, 3'd1, 32'hFFFF_8000);

    flt("lw_mis", 1'b0, 1'b1, DB + 2, 3'd2, 32'd0);
    flt("sh_mis", 1'b1, 1'b0, DB + 1, 3'd1, 32'h0000_FFFF);
    flt("lw_unmap", 1'b0, 1'b1, 32'h2000_0000, 3'd2, 32'd0);
    flt("rw_both", 1'b1, 1'b1, DB, 3'd2, 32'h0000_0000);
    flt("st_bad_f3", 1'b1, 1'b0, DB, 3'd4, 32'h0000_0000);
    flt("ld_bad_f3", 1'b0, 1'b1, DB, 3'd3, 32'd0);
    ld("lw_unchanged", DB, 3'd2, 32'h8000_12EF);

    st("sw_last", DB + 32'd4092, 3'd2, 32'h0BAD_F00D);
    ld("lw_last", DB + 32'd4092, 3'd2, 32'h0BAD_F00D);
    flt("lw_past_end", 1'b0, 1'b1, DB + 32'd4096, 3'd2, 32'd0);
    flt("lw_below", 1'b0, 1'b1, DB - 32'd4, 3'd2, 32'd0);
    flt("lw_mmio_end", 1'b0, 1'b1, MB + 32'h20, 3'd2, 32'd0);

    // Randomized RAM traffic over a 64-byte window.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      st("init", WB + 32'(4 * i), 3'd2, d);
      for (int b = 0; b < 4; b++) mb[4*i+b] = d[8*b +: 8];
    end
    for (int it = 0; it < 250; it++) begin
      off  = $urandom_range(0, 63);
      f    = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      w    = (kind <= 3) || (kind == 9);
      r    = (kind >= 4);
      a    = ($urandom_range(0, 7) == 0) ? 32'h2000_0000 + 32'(off) : WB + 32'(off);
      d    = $urandom;
      ef   = mfault(w, r, a, f);
      exp_rd = (r && !w && !ef) ? mload(off, f) : 32'd0;
      access(w, r, a, f, d);
      chk("rnd_fault", bus_fault, ef);
      if (r || ef) chk("rnd_rdata", bus_rdata, exp_rd);
      tick();
      if (w && !r && !ef) begin
        nb = 1 << f[1:0];
        for (int b = 0; b < nb; b++) mb[off+b] = d[8*b +: 8];
      end
    end
    for (int i = 0; i < 16; i++) ld("rnd_sweep", WB + 32'(4 * i), 3'd2, mload(4 * i, 3'd2));

    st("gpio_w", MB, 3'd2, 32'h0000_01A5);
    chk("gpio_out", gpio_out, 8'hA5);
    ld("gpio_r", MB, 3'd2, 32'h0000_00A5);
    flt("gpio_sb", 1'b1, 1'b0, MB, 3'd0, 32'h0000_0077);
    chk("gpio_keep", gpio_out, 8'hA5);
    flt("gpio_lb", 1'b0, 1'b1, MB, 3'd0, 32'd0);
    st("rsv_w", MB + 32'h1C, 3'd2, 32'hFFFF_FFFF);
    ld("rsv_r", MB + 32'h1C, 3'd2, 32'd0);
    ld("rsv_r14", MB + 32'h14, 3'd2, 32'd0);

    // Timer: compare at 5 sets pending when MTIME reaches 6.
    st("cmp_w", MB + 32'h10, 3'd2, 32'd5);
    st("ctrl_w", MB + 32'h04, 3'd2, 32'd3);
    st("mtime_w", MB + 32'h0C, 3'd2, 32'd0);
    seen = 1'b0; hit_at = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      access(1'b0, 1'b1, MB + 32'h08, 3'd2, 32'd0);
      if (bus_rdata[0] === 1'b1) begin
        seen = 1'b1; hit_at = i;
        chk("irq_lags_pend", timer_irq, 1'b0);
      end
      tick();
    end
    chk("pend_seen", seen, 1'b1);
    chk("pend_poll_idx", hit_at, 32'd6);
    access(1'b0, 1'b1, MB + 32'h0C, 3'd2, 32'd0);
    chk("mtime_after_pend", bus_rdata, 32'd7);
    chk("irq_set", timer_irq, 1'b1);
    tick();
    st("w1c", MB + 32'h08, 3'd2, 32'd1);
    ld("status_clr", MB + 32'h08, 3'd2, 32'd0);
    chk("irq_clr", timer_irq, 1'b0);
    st("mtime_max", MB + 32'h0C, 3'd2, 32'hFFFF_FFFF);
    ld("mtime_max_r", MB + 32'h0C, 3'd2, 32'hFFFF_FFFF);
    ld("mtime_wrap", MB + 32'h0C, 3'd2, 32'd0);

    // Reset while counting with the interrupt raised.
    st("gpio_w2", MB, 3'd2, 32'h0000_003C);
    st("mtime_w2", MB + 32'h0C, 3'd2, 32'd0);
    st("cmp_w2", MB + 32'h10, 3'd2, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (timer_irq === 1'b1) seen = 1'b1;
      else tick();
    end
    chk("irq_before_rst", seen, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_irq", timer_irq, 1'b0);
    chk("rst2_gpio", gpio_out, 8'h00);
    ld("rst2_mtime", MB + 32'h0C, 3'd2, 32'd0);
    ld("rst2_cmp", MB + 32'h10, 3'd2, 32'hFFFF_FFFF);
    ld("rst2_ctrl", MB + 32'h04, 3'd2, 32'd0);
    ld("rst2_ram_base", DB, 3'd2, 32'h8000_12EF);
    ld("rst2_ram_win", WB + 32'd8, 3'd2, mload(8, 3'd2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
